// File: rtl/selector_ajuste_campos.sv
// Field selector for time/date adjustment: four debounced buttons drive a
// two-state IDLE/ADJUST FSM that picks a field and emits up/down step pulses
// with auto-repeat and an inactivity timeout.

// Per-button 2-flop synchronizer followed by a consecutive-sample debouncer.
module selector_ajuste_campos_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Level flips only after DEB_CYCLES differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module selector_ajuste_campos #(
    parameter int DEB_CYCLES     = 500000,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_PERIOD  = 20000000,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       adjust_active
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, ADJUST} state_t;

    // bit 0 mode, 1 next, 2 up, 3 down
    logic [3:0] raw, lvl, lvl_q, press;
    logic [1:0] single_q;
    logic       single_up, single_dn, start_up, start_dn, tick, timeout, any_press, in_adjust;
    logic       up_req, dn_req;
    logic       rep_phase;
    logic [RW-1:0] rep_cnt;
    logic [IW-1:0] idle_cnt;
    state_t     state, state_n;
    logic [3:0] field, field_n;

    assign raw = {btn_down, btn_up, btn_next, btn_mode};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_deb
            selector_ajuste_campos_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .reset (reset),
                .raw   (raw[g]),
                .level (lvl[g])
            );
        end
    endgenerate

    // Previous debounced levels for press detection and single-button hold tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q    <= '0;
            single_q <= '0;
        end else begin
            lvl_q    <= lvl;
            single_q <= {single_dn, single_up};
        end
    end

    assign press     = lvl & ~lvl_q;
    assign any_press = |press;
    // Exactly one of up/down held; entering this condition behaves like a fresh press.
    assign single_up = lvl[2] & ~lvl[3];
    assign single_dn = lvl[3] & ~lvl[2];
    assign start_up  = single_up & ~single_q[0];
    assign start_dn  = single_dn & ~single_q[1];
    assign tick      = (single_up | single_dn) &
                       (rep_phase ? (rep_cnt == RW'(REPEAT_PERIOD)) : (rep_cnt == RW'(REPEAT_DELAY)));
    assign timeout   = (idle_cnt == IW'(TIMEOUT_CYCLES));
    assign in_adjust = (state == ADJUST) && (state_n == ADJUST);

    // Next state, field selection and step requests; mode beats next beats up/down.
    always_comb begin
        state_n = state;
        field_n = field;
        up_req  = 1'b0;
        dn_req  = 1'b0;
        case (state)
            IDLE: begin
                if (press[0]) begin
                    state_n = ADJUST;
                    field_n = 4'd1;
                end
            end
            ADJUST: begin
                if (press[0] || (timeout && !any_press)) begin
                    state_n = IDLE;
                    field_n = 4'd0;
                end else if (press[1]) begin
                    field_n = (field == 4'd6) ? 4'd1 : field + 4'd1;
                end else begin
                    up_req = (start_up | (tick & single_up)) & ~enUP;
                    dn_req = (start_dn | (tick & single_dn)) & ~enDOWN;
                end
            end
            default: begin
                state_n = IDLE;
                field_n = 4'd0;
            end
        endcase
    end

    // State, field and registered step pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            field  <= 4'd0;
            enUP   <= 1'b0;
            enDOWN <= 1'b0;
        end else begin
            state  <= state_n;
            field  <= field_n;
            enUP   <= up_req;
            enDOWN <= dn_req;
        end
    end

    // Auto-repeat timer: counts cycles since the last step while one button is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (!in_adjust) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (start_up || start_dn) begin
            rep_cnt   <= RW'(1);
            rep_phase <= 1'b0;
        end else if (single_up || single_dn) begin
            if (tick) begin
                rep_cnt   <= RW'(1);
                rep_phase <= 1'b1;
            end else if (rep_cnt != RW'(RMAX)) begin
                rep_cnt <= rep_cnt + RW'(1);
            end
        end else begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end
    end

    // Inactivity timer: cleared by any press or step, saturates at the timeout value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!in_adjust || any_press || up_req || dn_req) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    assign en_count      = field;
    assign adjust_active = (state == ADJUST);
endmodule

// File: tb/tb_selector_ajuste_campos.sv
// Directed bench for selector_ajuste_campos with small timing parameters.
module tb_selector_ajuste_campos;
    localparam int DEB = 4, RD = 20, RP = 5, TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'b0;  // 0 mode, 1 next, 2 up, 3 down
    logic [3:0] en_count;
    logic       en_up, en_down, adj;

    always #5 clk = ~clk;

    selector_ajuste_campos #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_mode      (btn[0]),
        .btn_next      (btn[1]),
        .btn_up        (btn[2]),
        .btn_down      (btn[3]),
        .en_count      (en_count),
        .enUP          (en_up),
        .enDOWN        (en_down),
        .adjust_active (adj)
    );

    int total = 0, passed = 0;
    int both_seen = 0, wide_seen = 0, adj_rises = 0, up_pulses = 0, any_step = 0;
    logic prev_up = 1'b0, prev_dn = 1'b0, prev_adj = 1'b0;

    // Continuous observation of pulse shape, exclusivity and mode entries.
    always @(negedge clk) begin
        if (en_up && en_down) both_seen <= both_seen + 1;
        if ((en_up && prev_up) || (en_down && prev_dn)) wide_seen <= wide_seen + 1;
        if (adj && !prev_adj) adj_rises <= adj_rises + 1;
        if (en_up) up_pulses <= up_pulses + 1;
        if (en_up || en_down) any_step <= any_step + 1;
        prev_up  <= en_up;
        prev_dn  <= en_down;
        prev_adj <= adj;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        step(12);
        btn[b] = 1'b0;
        step(12);
    endtask

    initial begin
        int n, n2, ng, s0;
        int gaps[4];
        int exp_seq[6];
        exp_seq = '{2, 3, 4, 5, 6, 1};

        // Reset state
        step(3);
        chk("rst_en_count", 32'(en_count), 0);
        chk("rst_enUP", 32'(en_up), 0);
        chk("rst_enDOWN", 32'(en_down), 0);
        chk("rst_adjust", 32'(adj), 0);
        reset = 1'b0;
        step(2);

        // Bouncing mode button, then steady hold
        for (int i = 0; i < 5; i++) begin
            btn[0] = (i % 2 == 0);
            step(2);
        end
        chk("bounce_still_idle", 32'(adj), 0);
        btn[0] = 1'b1;
        step(15);
        chk("enter_adjust", 32'(adj), 1);
        chk("enter_field", 32'(en_count), 1);
        chk("single_entry", 32'(adj_rises), 1);
        btn[0] = 1'b0;
        step(12);
        chk("release_no_action", 32'(adj), 1);
        chk("single_entry_after_release", 32'(adj_rises), 1);

        // Field cycling
        for (int i = 0; i < 6; i++) begin
            press(1);
            chk($sformatf("next_%0d", i), 32'(en_count), 32'(exp_seq[i]));
        end

        // Up held: first pulse, then auto-repeat spacing
        btn[2] = 1'b1;
        n = 0;
        while (n < 30 && en_up !== 1'b1) begin
            step(1);
            n++;
        end
        chk("up_first_latency", 32'(n), 7);
        ng = 0;
        gaps = '{-1, -1, -1, -1};
        for (int k = 1; k <= 37; k++) begin
            step(1);
            if (en_up) begin
                if (ng < 4) gaps[ng] = k;
                ng++;
            end
        end
        chk("repeat_count", 32'(ng), 4);
        chk("repeat_gap0", 32'(gaps[0]), 20);
        chk("repeat_gap1", 32'(gaps[1]), 25);
        chk("repeat_gap2", 32'(gaps[2]), 30);
        chk("repeat_gap3", 32'(gaps[3]), 35);
        btn[2] = 1'b0;
        step(12);
        chk("field_kept", 32'(en_count), 1);

        // Up and down together, then release down
        s0 = any_step;
        btn[2] = 1'b1;
        btn[3] = 1'b1;
        step(40);
        chk("both_no_step", 32'(any_step - s0), 0);
        btn[3] = 1'b0;
        n = 0;
        while (n < 30 && en_up !== 1'b1) begin
            step(1);
            n++;
        end
        chk("down_release_latency", 32'(n), 7);
        n2 = 0;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            if (en_up && n2 == 0) n2 = k;
        end
        chk("restart_delay", 32'(n2), 20);
        btn[2] = 1'b0;
        step(12);

        // Leave, re-enter, then inactivity timeout
        press(0);
        chk("mode_exit", 32'(adj), 0);
        chk("mode_exit_field", 32'(en_count), 0);
        press(0);
        chk("reenter_field", 32'(en_count), 1);
        step(70);
        chk("no_timeout_yet", 32'(adj), 1);
        step(20);
        chk("timeout_adjust", 32'(adj), 0);
        chk("timeout_field", 32'(en_count), 0);
        s0 = up_pulses;
        press(2);
        chk("idle_up_no_pulse", 32'(up_pulses - s0), 0);
        chk("idle_up_stays_idle", 32'(adj), 0);

        // Reset during a step pulse on field 3
        press(0);
        press(1);
        press(1);
        chk("field_before_reset", 32'(en_count), 3);
        btn[2] = 1'b1;
        n = 0;
        while (n < 30 && en_up !== 1'b1) begin
            step(1);
            n++;
        end
        chk("pulse_before_reset", 32'(en_up), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_enUP", 32'(en_up), 0);
        chk("async_rst_enDOWN", 32'(en_down), 0);
        chk("async_rst_field", 32'(en_count), 0);
        chk("async_rst_adjust", 32'(adj), 0);
        btn[2] = 1'b0;
        btn[0] = 1'b1;
        step(3);
        reset = 1'b0;
        step(3);
        chk("idle_after_reset", 32'(adj), 0);
        step(15);
        chk("held_through_reset", 32'(adj), 1);
        btn[0] = 1'b0;
        step(12);

        chk("never_both_steps", 32'(both_seen), 0);
        chk("steps_one_cycle", 32'(wide_seen), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/selector_ajuste_campos.md
SELECTOR_AJUSTE_CAMPOS -- requirements
Module: selector_ajuste_campos

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter: DEB_CYCLES, default 500000, number of consecutive identical samples required to accept a new button level.
REQ-003 Parameter: REPEAT_DELAY, default 50000000, number of held cycles before up/down auto-repeat starts.
REQ-004 Parameter: REPEAT_PERIOD, default 20000000, number of cycles between auto-repeat steps.
REQ-005 Parameter: TIMEOUT_CYCLES, default 1000000000, number of idle cycles in adjust mode before returning to normal mode.
REQ-006 Port: clk  input  1  system clock.
REQ-007 Port: reset  input  1  asynchronous active-high reset.
REQ-008 Port: btn_mode  input  1  raw button, asynchronous and bouncing; toggles adjust mode.
REQ-009 Port: btn_next  input  1  raw button; selects the next field.
REQ-010 Port: btn_up  input  1  raw button; increments the selected field.
REQ-011 Port: btn_down  input  1  raw button; decrements the selected field.
REQ-012 Port: en_count  output  4  selected-field code: 0 none, 1 seconds, 2 minutes, 3 hours, 4 day, 5 month, 6 year.
REQ-013 Port: enUP  output  1  registered one-cycle increment step pulse.
REQ-014 Port: enDOWN  output  1  registered one-cycle decrement step pulse.
REQ-015 Port: adjust_active  output  1  high while in the ADJUST state.

Function
REQ-016 Each raw button SHALL pass through a 2-flop synchronizer and then an independent debouncer.
REQ-017 Each debouncer SHALL change its output only after DEB_CYCLES consecutive synchronized samples that differ from its current output.
REQ-018 Any sample equal to the current debouncer output SHALL restart that debouncer's count.
REQ-019 A "press" SHALL be a 0->1 transition of a debounced button level; releases SHALL produce no action.
REQ-020 The FSM SHALL have exactly two states: IDLE and ADJUST.
REQ-021 In IDLE: en_count=0, enUP=0, enDOWN=0, adjust_active=0; only a btn_mode press has an effect.
REQ-022 A btn_mode press in IDLE SHALL move the FSM to ADJUST with en_count=1.
REQ-023 A btn_mode press in ADJUST SHALL move the FSM to IDLE.
REQ-024 A btn_next press in ADJUST SHALL advance en_count 1->2->...->6->1.
REQ-025 A btn_mode press SHALL take priority over a btn_next, btn_up or btn_down press in the same cycle; the other presses in that cycle SHALL be discarded.
REQ-026 A btn_next press in the same cycle as an up/down press SHALL advance the field and suppress the step.
REQ-027 In ADJUST, a btn_up press SHALL assert enUP for exactly one cycle, in the cycle after the debounced rising edge.
REQ-028 In ADJUST, a btn_down press SHALL assert enDOWN for exactly one cycle, under the same timing rule as enUP.
REQ-029 While exactly one of up/down stays debounced-high, the block SHALL emit a second pulse REPEAT_DELAY cycles after the first, then one every REPEAT_PERIOD cycles.
REQ-030 If debounced up and down are both high, no pulses SHALL be emitted and the repeat counter SHALL clear.
REQ-031 Auto-repeat SHALL restart from the first-pulse rule when only one button remains held.
REQ-032 enUP and enDOWN SHALL never both be high in the same cycle.
REQ-033 Both step outputs SHALL always return low for at least 1 cycle between pulses.
REQ-034 An inactivity counter SHALL clear on any press or on any auto-repeat pulse.
REQ-035 When the inactivity counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE.
REQ-036 Leaving ADJUST by any means SHALL clear the repeat and inactivity counters.
REQ-037 All counters SHALL be sized to ceil(log2(parameter+1)) bits and SHALL saturate rather than wrap.

Reset
REQ-038 During reset: state=IDLE, en_count=0, enUP=0, enDOWN=0, adjust_active=0.
REQ-039 During reset, all synchronizer flops, debounced levels and counters SHALL be 0.
REQ-040 Reset asserted in mid-operation SHALL take effect immediately and asynchronously, including while a step pulse is high.
REQ-041 A button held through reset release SHALL register as a press once debounced.

Verification (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT_CYCLES=100)
REQ-042 Bounce btn_mode 0/1 every 2 cycles for 10 cycles, then hold 1 -> exactly one transition to ADJUST, en_count=1, adjust_active=1.
REQ-043 In ADJUST, press btn_next 6 times -> en_count sequence 2,3,4,5,6,1.
REQ-044 In ADJUST, hold btn_up for 40 cycles after debounce -> enUP pulses at offsets 1, 21, 26, 31, 36, each exactly 1 cycle wide.
REQ-045 Hold btn_up and btn_down together -> enUP=enDOWN=0 throughout; release btn_down -> first-pulse rule applies to up.
REQ-046 Enter ADJUST, apply no presses for 100 cycles -> en_count=0, adjust_active=0; a btn_up press afterward -> no pulse.
REQ-047 Assert reset while enUP=1 and en_count=3 -> all outputs 0 immediately, FSM in IDLE after release.
